encrypt_sched: RTL and testbench

Round-robin scheduler that shares one pipelined Twofish encryption core (`encrypt_out`: fixed latency, no stall, one block per cycle) between `N_REQ` requesters. It tracks every issued block with a requester tag through the core latency. Each ciphertext lands in an output FIFO and returns on a single valid/ready result stream. Credit-based admission guarantees the FIFO can never overflow, because the core cannot be stalled.

---
 rtl/twofish_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/encrypt_sched.sv | 175 +++++++++++++++++
 tb/tb_encrypt_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twofish_pkg.sv
// Shared types for the Twofish request scheduler.
// Tag width is sized for the largest supported requester count.
package twofish_pkg;

  localparam int BLOCK_W  = 128;
  localparam int KEY_W    = 128;
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The first request at or after ptr wins, wrapping modulo N.
module rr_arbiter
  import twofish_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_src;

  always_comb begin
    w_mask = '0;
    for (int j = 0; j < N; j++) begin
      w_mask[j] = (j >= int'(ptr));
    end
    w_hi  = req & w_mask;
    // Fall back to the wrapped-around set when nothing is at/after ptr.
    w_src = (|w_hi) ? w_hi : req;
    grant = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_src[j]) grant = N'(1) << j;
    end
  end

endmodule

// File: rtl/encrypt_sched.sv
// Shares one fixed-latency encryption core between N_REQ requesters.
// Credit admission keeps the result FIFO from ever overflowing.
module encrypt_sched
  import twofish_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int LATENCY = 17,
  parameter  int DEPTH   = 32,
  localparam int IDW     = id_w(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*BLOCK_W-1:0] req_plain_text,
  input  logic [N_REQ*KEY_W-1:0]   req_key,
  output logic [BLOCK_W-1:0]       core_plain_text,
  output logic [KEY_W-1:0]         core_key,
  input  logic [BLOCK_W-1:0]       core_cipher,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [BLOCK_W-1:0]       res_data,
  output logic [IDW-1:0]           res_id
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = BLOCK_W + IDW;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  logic [N_REQ-1:0]   w_grant;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     w_gid;
  logic [IDW-1:0]     w_ptr_nxt;
  logic [BLOCK_W-1:0] w_pt;
  logic [KEY_W-1:0]   w_key;
  logic               w_acc;
  logic               w_credit_ok;
  logic [CW:0]        w_used;

  logic [BLOCK_W-1:0] r_core_pt;
  logic [KEY_W-1:0]   r_core_key;
  logic [CW-1:0]      r_inflight;

  tag_t               r_tags [LATENCY];
  tag_t               w_tag_in;
  tag_t               w_exit;
  logic               w_wr;
  logic               w_unused_id;

  logic [EW-1:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [CW-1:0]      r_mem_cnt;
  logic               w_load;
  logic               r_res_valid;
  logic [BLOCK_W-1:0] r_res_data;
  logic [IDW-1:0]     r_res_id;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .req  (req_valid),
    .ptr  (r_rr_ptr),
    .grant(w_grant)
  );

  // Output register counts as FIFO occupancy.
  assign w_used = {1'b0, r_inflight}
                + {1'b0, r_mem_cnt}
                + (CW+1)'(r_res_valid);
  assign w_credit_ok = (w_used < LP_DEPTH);

  assign req_ready = (!reset && w_credit_ok)
                   ? w_grant : '0;
  assign w_acc     = |(req_valid & req_ready);

  always_comb begin
    w_gid = '0;
    w_pt  = '0;
    w_key = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_gid = IDW'(i);
        w_pt  = req_plain_text[i*BLOCK_W +: BLOCK_W];
        w_key = req_key[i*KEY_W +: KEY_W];
      end
    end
  end

  assign w_ptr_nxt = (int'(w_gid) == N_REQ - 1)
                   ? '0 : w_gid + 1'b1;

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_acc;
    w_tag_in.id    = ID_MAX_W'(w_gid);
  end

  assign w_exit      = r_tags[LATENCY-1];
  assign w_wr        = w_exit.valid;
  assign w_unused_id = ^w_exit.id;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_core_pt  <= '0;
      r_core_key <= '0;
      r_inflight <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tags[i] <= '0;
      end
    end else begin
      if (w_acc) begin
        r_core_pt  <= w_pt;
        r_core_key <= w_key;
        r_rr_ptr   <= w_ptr_nxt;
      end
      r_tags[0] <= w_tag_in;
      for (int i = 1; i < LATENCY; i++) begin
        r_tags[i] <= r_tags[i-1];
      end
      if (w_acc && !w_wr) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (!w_acc && w_wr) begin
        r_inflight <= r_inflight - 1'b1;
      end
    end
  end

  assign core_plain_text = r_core_pt;
  assign core_key        = r_core_key;

  // Head is prefetched into the output register; no fall-through.
  assign w_load = (r_mem_cnt != '0)
               && (!r_res_valid || res_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_mem_cnt   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_load) begin
        r_rp        <= r_rp + 1'b1;
        r_res_valid <= 1'b1;
        {r_res_data, r_res_id} <= r_mem[r_rp];
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end
      if (w_wr && !w_load) begin
        r_mem_cnt <= r_mem_cnt + 1'b1;
      end else if (!w_wr && w_load) begin
        r_mem_cnt <= r_mem_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr) begin
      r_mem[r_wp] <= {core_cipher, w_exit.id[IDW-1:0]};
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_encrypt_sched.sv
// Scoreboard bench for encrypt_sched with a behavioural core model.
// Monitors push expectations on accept and check results on pop.
module tb_encrypt_sched;

  localparam int N_REQ   = 2;
  localparam int LATENCY = 17;
  localparam int DEPTH   = 32;
  localparam int IDW     = 1;

  localparam logic [127:0] PT0 =
    128'hD491DB16E7B1C39E86CB086B789F5419;
  localparam logic [127:0] K0 =
    128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;
  localparam logic [127:0] CT0 =
    128'h019F9809DE1711858FAAC3A3BA20FBC3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*128-1:0] req_plain_text;
  logic [N_REQ*128-1:0] req_key;
  logic [127:0]         core_plain_text;
  logic [127:0]         core_key;
  logic [127:0]         core_cipher;
  logic                 res_valid;
  logic                 res_ready;
  logic [127:0]         res_data;
  logic [IDW-1:0]       res_id;

  always #5 clk = ~clk;

  encrypt_sched #(
    .N_REQ  (N_REQ),
    .LATENCY(LATENCY),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_plain_text (req_plain_text),
    .req_key        (req_key),
    .core_plain_text(core_plain_text),
    .core_key       (core_key),
    .core_cipher    (core_cipher),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_id         (res_id)
  );

  // Stand-in cipher: the known vector maps to its real ciphertext.
  function automatic logic [127:0] core_fn(
    input logic [127:0] p, input logic [127:0] k);
    if (p == PT0 && k == K0) return CT0;
    return p ^ {k[63:0], k[127:64]}
             ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  logic [127:0] core_pipe [LATENCY-1];
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(core_plain_text, core_key);
    for (int i = 1; i < LATENCY - 1; i++)
      core_pipe[i] <= core_pipe[i-1];
  end
  assign core_cipher = core_pipe[LATENCY-2];

  typedef struct {
    logic [127:0]   d;
    logic [IDW-1:0] id;
    int             acyc;
  } exp_t;

  exp_t           exp_q [$];
  logic [255:0]   src_q [N_REQ][$];
  int             gnt_log [$];
  int             acyc_log [$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             acc_cnt = 0;
  int             rv_cnt = 0;
  int             gap_seen = 0;
  int             last_rc = 0;
  logic [N_REQ-1:0] acc_mask = '0;
  bit             lat_mode = 1'b0;
  bit             gap_mode = 1'b0;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance monitor: one expectation per handshake.
  always @(negedge clk) begin : acc_mon
    exp_t e;
    acc_mask = reset ? '0 : (req_valid & req_ready);
    if (reset) exp_q.delete();
    for (int i = 0; i < N_REQ; i++) begin
      if (acc_mask[i]) begin
        e.d    = core_fn(req_plain_text[128*i +: 128],
                         req_key[128*i +: 128]);
        e.id   = IDW'(i);
        e.acyc = cyc;
        exp_q.push_back(e);
        gnt_log.push_back(i);
        acyc_log.push_back(cyc);
        acc_cnt++;
        check("outstanding_le_depth",
              128'(exp_q.size() <= DEPTH), 128'd1);
      end
    end
  end

  // Result monitor.
  always @(negedge clk) begin : res_mon
    exp_t e;
    if (!gap_mode) gap_seen = 0;
    if (!reset) begin
      if (res_valid) rv_cnt++;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", res_data, 128'hx);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e.d);
          check("res_id", 128'(res_id), 128'(e.id));
          if (lat_mode)
            check("latency", 128'(cyc - e.acyc - 1),
                  128'(LATENCY + 1));
          if (gap_mode) begin
            if (gap_seen > 0)
              check("gap_spacing", 128'(cyc - last_rc), 128'd3);
            gap_seen++;
            last_rc = cyc;
          end
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        {req_plain_text[128*i +: 128],
         req_key[128*i +: 128]} = src_q[i][0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++)
      if (acc_mask[i] && src_q[i].size() > 0)
        src_q[i].delete(0);
    drive();
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < N_REQ; i++) src_q[i].delete();
    drive();
    repeat (n) tick();
    reset = 1'b0;
  endtask

  function automatic bit pending();
    bit p = (exp_q.size() > 0);
    for (int i = 0; i < N_REQ; i++)
      if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while (pending() && n < 400) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 128'(n < 400), 128'd1);
  endtask

  function automatic logic [255:0] blk(input int r,
                                       input int k);
    return {32'(r), 32'(k), 64'h0123456789abcdef,
            64'hfeedface00c0ffee, 32'(k * 7), 32'(r)};
  endfunction

  initial begin : main
    int a0;
    int base;
    int r0;
    req_valid      = '0;
    req_plain_text = '0;
    req_key        = '0;
    res_ready      = 1'b1;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 128'(req_ready), 128'd0);
    check("rst_core_pt", core_plain_text, 128'd0);
    check("rst_core_key", core_key, 128'd0);
    check("rst_res_valid", 128'(res_valid), 128'd0);
    check("rst_res_data", res_data, 128'd0);
    check("rst_res_id", 128'(res_id), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Known vector
    lat_mode = 1'b1;
    a0 = acc_cnt;
    src_q[0].push_back({PT0, K0});
    drive();
    wait_drain("single");
    check("single_accepts", 128'(acc_cnt - a0), 128'd1);

    // Fairness
    apply_reset(2);
    base = gnt_log.size();
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < N_REQ; r++)
        src_q[r].push_back(blk(r, k));
    drive();
    wait_drain("fair");
    check("fair_accepts", 128'(gnt_log.size() - base), 128'd8);
    if (gnt_log.size() - base >= 8) begin
      for (int k = 0; k < 8; k++)
        check($sformatf("grant_order_%0d", k),
              128'(gnt_log[base+k]), 128'(k % 2));
      check("fair_back_to_back",
            128'(acyc_log[base+7] - acyc_log[base]), 128'd7);
    end

    // Backpressure
    apply_reset(2);
    lat_mode  = 1'b0;
    res_ready = 1'b0;
    a0 = acc_cnt;
    for (int k = 0; k < 40; k++) src_q[0].push_back(blk(0, k + 100));
    drive();
    repeat (45) tick();
    check("bp_accepts_full", 128'(acc_cnt - a0), 128'(DEPTH));
    check("bp_ready_low", 128'(req_ready), 128'd0);
    check("bp_res_valid", 128'(res_valid), 128'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    repeat (10) tick();
    check("bp_one_more", 128'(acc_cnt - a0), 128'(DEPTH + 1));
    check("bp_ready_low2", 128'(req_ready), 128'd0);
    res_ready = 1'b1;
    wait_drain("bp");
    check("bp_total", 128'(acc_cnt - a0), 128'd40);
    lat_mode = 1'b1;

    // Steady state: accept, exit and pop every cycle
    apply_reset(2);
    a0   = acc_cnt;
    base = acyc_log.size();
    for (int k = 0; k < 40; k++) src_q[0].push_back(blk(0, k + 200));
    drive();
    wait_drain("steady");
    check("steady_accepts", 128'(acc_cnt - a0), 128'd40);
    if (acyc_log.size() - base >= 40)
      check("steady_no_bubble",
            128'(acyc_log[base+39] - acyc_log[base]), 128'd39);

    // Reset with blocks in flight
    apply_reset(2);
    a0 = acc_cnt;
    for (int k = 0; k < 10; k++) src_q[0].push_back(blk(0, k + 300));
    drive();
    repeat (12) tick();
    check("mid_inflight", 128'(acc_cnt - a0), 128'd10);
    apply_reset(1);
    r0 = rv_cnt;
    repeat (30) tick();
    check("no_stale_result", 128'(rv_cnt - r0), 128'd0);
    base = gnt_log.size();
    src_q[0].push_back(blk(0, 400));
    src_q[1].push_back(blk(1, 400));
    drive();
    wait_drain("post_reset");
    check("post_reset_accepts", 128'(gnt_log.size() - base), 128'd2);
    if (gnt_log.size() > base)
      check("post_reset_grant0", 128'(gnt_log[base]), 128'd0);

    // Idle gaps
    apply_reset(2);
    gap_mode = 1'b1;
    a0 = acc_cnt;
    for (int k = 0; k < 5; k++) begin
      src_q[0].push_back(blk(0, k + 500));
      drive();
      repeat (3) tick();
    end
    wait_drain("gaps");
    check("gap_results", 128'(gap_seen), 128'd5);
    gap_mode = 1'b0;
    check("gap_accepts", 128'(acc_cnt - a0), 128'd5);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
